// File: rtl/alu_op_sequencer.sv
// Multi-cycle control sequencer: walks FETCH/DECODE/EXEC/MEM/WB for one instruction per Start.
// Optional feature: define ALU_SEQ_VARSHIFT_EN to decode variable shifts (Funct 04/06/07).
module alu_op_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       Start,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic [4:0] ALUConf,
  output logic       Sign,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ExtOp,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       Busy,
  output logic       Done,
  output logic       Illegal
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB} state_t;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_OR  = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_SUB = 5'b00110;
  localparam logic [4:0] ALU_SLT = 5'b00111;
  localparam logic [4:0] ALU_NOR = 5'b01100;
  localparam logic [4:0] ALU_XOR = 5'b01101;
  localparam logic [4:0] ALU_SRL = 5'b10000;
  localparam logic [4:0] ALU_SRA = 5'b11000;
  localparam logic [4:0] ALU_SLL = 5'b11001;

  state_t     state, next;
  logic [5:0] op_q, funct_q;

  logic [4:0] ex_alu;
  logic       ex_sign, ex_ext, legal, is_branch, is_lw, is_sw;
  logic [1:0] ex_a, ex_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      op_q    <= '0;
      funct_q <= '0;
    end else begin
      state <= next;
      if (state == FETCH) begin
        op_q    <= OpCode;
        funct_q <= Funct;
      end
    end
  end

  // Instruction decode from the captured fields; only consumed in EXEC/MEM.
  always_comb begin
    ex_alu    = ALU_ADD;
    ex_sign   = 1'b0;
    ex_ext    = 1'b0;
    ex_a      = 2'd1;
    ex_b      = 2'd0;
    legal     = 1'b1;
    is_branch = 1'b0;
    is_lw     = 1'b0;
    is_sw     = 1'b0;
    case (op_q)
      6'h00: begin
        case (funct_q)
          6'h20: begin ex_alu = ALU_ADD; ex_sign = 1'b1; end
          6'h21: ex_alu = ALU_ADD;
          6'h22: begin ex_alu = ALU_SUB; ex_sign = 1'b1; end
          6'h23: ex_alu = ALU_SUB;
          6'h24: ex_alu = ALU_AND;
          6'h25: ex_alu = ALU_OR;
          6'h26: ex_alu = ALU_XOR;
          6'h27: ex_alu = ALU_NOR;
          6'h2A: begin ex_alu = ALU_SLT; ex_sign = 1'b1; end
          6'h2B: ex_alu = ALU_SLT;
          6'h00: begin ex_alu = ALU_SLL; ex_a = 2'd2; end
          6'h02: begin ex_alu = ALU_SRL; ex_a = 2'd2; end
          6'h03: begin ex_alu = ALU_SRA; ex_a = 2'd2; end
`ifdef ALU_SEQ_VARSHIFT_EN
          6'h04: ex_alu = ALU_SLL;
          6'h06: ex_alu = ALU_SRL;
          6'h07: ex_alu = ALU_SRA;
`endif
          default: legal = 1'b0;
        endcase
      end
      6'h08: begin ex_alu = ALU_ADD; ex_b = 2'd2; ex_ext = 1'b1; ex_sign = 1'b1; end
      6'h09: begin ex_alu = ALU_ADD; ex_b = 2'd2; ex_ext = 1'b1; end
      6'h0A: begin ex_alu = ALU_SLT; ex_b = 2'd2; ex_ext = 1'b1; ex_sign = 1'b1; end
      6'h0B: begin ex_alu = ALU_SLT; ex_b = 2'd2; ex_ext = 1'b1; end
      6'h0C: begin ex_alu = ALU_AND; ex_b = 2'd2; end
      6'h0D: begin ex_alu = ALU_OR;  ex_b = 2'd2; end
      6'h0F: begin ex_alu = ALU_SLL; ex_a = 2'd3; ex_b = 2'd2; end
      6'h23: begin ex_alu = ALU_ADD; ex_b = 2'd2; ex_ext = 1'b1; is_lw = 1'b1; end
      6'h2B: begin ex_alu = ALU_ADD; ex_b = 2'd2; ex_ext = 1'b1; is_sw = 1'b1; end
      6'h04, 6'h05: begin ex_alu = ALU_SUB; is_branch = 1'b1; end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    next        = state;
    ALUConf     = ALU_ADD;
    Sign        = 1'b0;
    ALUSrcA     = 2'd0;
    ALUSrcB     = 2'd0;
    ExtOp       = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    RegWrite    = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    Done        = 1'b0;
    Illegal     = 1'b0;
    Busy        = (state != IDLE);
    case (state)
      IDLE:   if (Start) next = FETCH;
      FETCH: begin
        ALUSrcB = 2'd1;
        PCWrite = 1'b1;
        next    = DECODE;
      end
      DECODE: begin
        ALUSrcB = 2'd3;
        ExtOp   = 1'b1;
        next    = EXEC;
      end
      EXEC: begin
        if (!legal) begin
          Illegal = 1'b1;
          Done    = 1'b1;
          next    = IDLE;
        end else begin
          ALUConf = ex_alu;
          Sign    = ex_sign;
          ALUSrcA = ex_a;
          ALUSrcB = ex_b;
          ExtOp   = ex_ext;
          if (is_branch) begin
            // OpCode bit 0 distinguishes bne (05) from beq (04).
            PCWriteCond = op_q[0] ? ~Zero : Zero;
            Done        = 1'b1;
            next        = IDLE;
          end else if (is_lw || is_sw) begin
            next = MEM;
          end else begin
            next = WB;
          end
        end
      end
      MEM: begin
        MemRead  = is_lw;
        MemWrite = is_sw;
        Done     = is_sw;
        next     = is_sw ? IDLE : WB;
      end
      WB: begin
        RegWrite = 1'b1;
        Done     = 1'b1;
        next     = IDLE;
      end
      default: next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: expected per-cycle control vectors are queued at Start.
module tb_alu_op_sequencer;
  logic       clk = 1'b0;
  logic       reset, Start, Zero;
  logic [5:0] OpCode, Funct;
  logic [4:0] ALUConf;
  logic       Sign, ExtOp, PCWrite, PCWriteCond, RegWrite, MemRead, MemWrite, Busy, Done, Illegal;
  logic [1:0] ALUSrcA, ALUSrcB;

  int errors = 0;
  int checks = 0;
  logic [18:0] exp_q[$];
  logic [18:0] obs;

  alu_op_sequencer dut (
    .clk(clk), .reset(reset), .Start(Start), .OpCode(OpCode), .Funct(Funct), .Zero(Zero),
    .ALUConf(ALUConf), .Sign(Sign), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtOp(ExtOp),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .Busy(Busy), .Done(Done), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  assign obs = {ALUConf, Sign, ALUSrcA, ALUSrcB, ExtOp, PCWrite, PCWriteCond,
                RegWrite, MemRead, MemWrite, Busy, Done, Illegal};

  function automatic logic [18:0] mk(input logic [4:0] alu, input logic sg, input logic [1:0] a,
                                     input logic [1:0] b, input logic ext, input logic pcw,
                                     input logic pcc, input logic rw, input logic mr,
                                     input logic mw, input logic bsy, input logic dn,
                                     input logic il);
    return {alu, sg, a, b, ext, pcw, pcc, rw, mr, mw, bsy, dn, il};
  endfunction

  // Reference decode: returns EXEC vector and the tail kind (0 none, 1 WB, 2 lw, 3 sw).
  task automatic push_expected(input logic [5:0] op, input logic [5:0] f, input logic z);
    logic [18:0] ex;
    int unsigned tail;
    ex   = mk(5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    tail = 0;
    if (op == 6'h00) begin
      tail = 1;
      case (f)
        6'h20: ex = mk(5'b00000, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        6'h21: ex = mk(5'b00000, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        6'h22: ex = mk(5'b00110, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        6'h23: ex = mk(5'b00110, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        6'h24: ex = mk(5'b00010, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        6'h25: ex = mk(5'b00001, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        6'h26: ex = mk(5'b01101, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        6'h27: ex = mk(5'b01100, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        6'h2A: ex = mk(5'b00111, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        6'h2B: ex = mk(5'b00111, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        6'h00: ex = mk(5'b11001, 0, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        6'h02: ex = mk(5'b10000, 0, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        6'h03: ex = mk(5'b11000, 0, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
`ifdef ALU_SEQ_VARSHIFT_EN
        6'h04: ex = mk(5'b11001, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        6'h06: ex = mk(5'b10000, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        6'h07: ex = mk(5'b11000, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
`endif
        default: tail = 0;
      endcase
    end else begin
      tail = 1;
      case (op)
        6'h08: ex = mk(5'b00000, 1, 1, 2, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        6'h09: ex = mk(5'b00000, 0, 1, 2, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        6'h0A: ex = mk(5'b00111, 1, 1, 2, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        6'h0B: ex = mk(5'b00111, 0, 1, 2, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        6'h0C: ex = mk(5'b00010, 0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        6'h0D: ex = mk(5'b00001, 0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        6'h0F: ex = mk(5'b11001, 0, 3, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        6'h23: begin ex = mk(5'b00000, 0, 1, 2, 1, 0, 0, 0, 0, 0, 1, 0, 0); tail = 2; end
        6'h2B: begin ex = mk(5'b00000, 0, 1, 2, 1, 0, 0, 0, 0, 0, 1, 0, 0); tail = 3; end
        6'h04: begin ex = mk(5'b00110, 0, 1, 0, 0, 0, z, 0, 0, 0, 1, 1, 0); tail = 0; end
        6'h05: begin ex = mk(5'b00110, 0, 1, 0, 0, 0, !z, 0, 0, 0, 1, 1, 0); tail = 0; end
        default: tail = 0;
      endcase
    end
    exp_q.push_back(mk(5'b00000, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0));
    exp_q.push_back(mk(5'b00000, 0, 0, 3, 1, 0, 0, 0, 0, 0, 1, 0, 0));
    exp_q.push_back(ex);
    if (tail == 2) exp_q.push_back(mk(5'b00000, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    if (tail == 3) exp_q.push_back(mk(5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0));
    if (tail == 1 || tail == 2) exp_q.push_back(mk(5'b00000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0));
    exp_q.push_back('0);
  endtask

  // Entered #1 after a posedge with the DUT idle; Start stays high to show it is ignored.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] f,
                           input logic z);
    logic [18:0] e;
    int unsigned cyc;
    push_expected(op, f, z);
    Start  = 1'b1;
    OpCode = op;
    Funct  = f;
    Zero   = z;
    cyc    = 0;
    @(posedge clk); #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs !== e) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, obs, e);
      end
      checks++;
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
      OpCode = 6'($urandom);
      Funct  = 6'($urandom);
      cyc++;
    end
    Start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; Start = 1'b1; OpCode = 6'h00; Funct = 6'h22; Zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if (obs !== 19'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected %h", obs, 19'd0);
    end
    checks++;
    reset = 1'b0; Start = 1'b0;
    @(posedge clk); #1;
    if (obs !== 19'd0) begin
      errors++; $display("FAIL idle_after_reset: got %h expected %h", obs, 19'd0);
    end
    checks++;
  endtask

  task automatic test_rtype;
    logic [5:0] fl[13] = '{6'h22, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                           6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};
    foreach (fl[i]) run_instr($sformatf("rtype_f%0h", fl[i]), 6'h00, fl[i], 1'b0);
  endtask

  task automatic test_branch;
    run_instr("beq_z1", 6'h04, 6'h3F, 1'b1);
    run_instr("beq_z0", 6'h04, 6'h3F, 1'b0);
    run_instr("bne_z1", 6'h05, 6'h00, 1'b1);
    run_instr("bne_z0", 6'h05, 6'h00, 1'b0);
  endtask

  task automatic test_load_store;
    run_instr("lw", 6'h23, 6'h11, 1'b0);
    run_instr("sw", 6'h2B, 6'h11, 1'b0);
  endtask

  task automatic test_itype;
    logic [5:0] ol[7] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0F};
    foreach (ol[i]) run_instr($sformatf("itype_op%0h", ol[i]), ol[i], 6'h15, 1'b0);
  endtask

  task automatic test_illegal;
    run_instr("ill_funct01", 6'h00, 6'h01, 1'b0);
    run_instr("ill_op3f", 6'h3F, 6'h20, 1'b0);
    run_instr("varshift_f04", 6'h00, 6'h04, 1'b0);
    run_instr("varshift_f06", 6'h00, 6'h06, 1'b0);
    run_instr("varshift_f07", 6'h00, 6'h07, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_instr("b2b_sw", 6'h2B, 6'h00, 1'b0);
    run_instr("b2b_beq", 6'h04, 6'h00, 1'b1);
    run_instr("b2b_add", 6'h00, 6'h20, 1'b0);
  endtask

  task automatic test_reset_mid_lw;
    logic [18:0] e_exec;
    e_exec = mk(5'b00000, 0, 1, 2, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    Start = 1'b1; OpCode = 6'h23; Funct = 6'h00;
    repeat (3) @(posedge clk);
    #1;
    if (obs !== e_exec) begin
      errors++; $display("FAIL rst_mid_exec: got %h expected %h", obs, e_exec);
    end
    checks++;
    reset = 1'b1;
    @(posedge clk); #1;
    if (obs !== 19'd0) begin
      errors++; $display("FAIL rst_mid_idle: got %h expected %h", obs, 19'd0);
    end
    checks++;
    reset = 1'b0; Start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (obs !== 19'd0) begin
        errors++; $display("FAIL rst_mid_no_strobe: got %h expected %h", obs, 19'd0);
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_branch();
    test_load_store();
    test_itype();
    test_illegal();
    test_back_to_back();
    test_reset_mid_lw();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
